// File: rtl/hovalaag_io_bridge.sv
// Host-side I/O bridge for the Hovalaag CPU: two input queues feeding IN1/IN2 and
// two output queues capturing the OUT stream, with sticky underflow/overflow flags.

module hovalaag_fifo #(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [11:0]   wdata,
  output logic [11:0]   rdata,
  output logic [CW-1:0] count,
  output logic          full
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr, rd_ptr;
  logic [AW:0]  diff;
  logic [11:0]  mem [DEPTH];
  logic         empty, do_push, do_pop;

  // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign diff    = wr_ptr - rd_ptr;
  assign count   = CW'(diff);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = empty ? 12'h000 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage carries no reset; stale entries are hidden behind the empty mask.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end
endmodule

module hovalaag_io_bridge #(
  parameter  int DEPTH = 16,
  localparam int CW    = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_wr_en,
  input  logic          in_wr_sel,
  input  logic [11:0]   in_wr_data,
  output logic [CW-1:0] in1_count,
  output logic [CW-1:0] in2_count,
  output logic [11:0]   IN1,
  output logic [11:0]   IN2,
  input  logic          IN1_adv,
  input  logic          IN2_adv,
  input  logic [11:0]   OUT,
  input  logic          OUT_valid,
  input  logic          OUT_select,
  input  logic          out_rd_en,
  input  logic          out_rd_sel,
  output logic [11:0]   out1_data,
  output logic [11:0]   out2_data,
  output logic [CW-1:0] out1_count,
  output logic [CW-1:0] out2_count,
  output logic [1:0]    underflow,
  output logic [3:0]    overflow,
  input  logic          err_clr
);
  // Queue order: 0 = IN1, 1 = IN2, 2 = OUT1, 3 = OUT2.
  logic [3:0]           push, pop, full;
  logic [3:0][11:0]     wdata, head;
  logic [3:0][CW-1:0]   cnt;
  logic [3:0]           ovf_ev;
  logic [1:0]           unf_ev;

  assign push  = {OUT_valid & OUT_select, OUT_valid & ~OUT_select,
                  in_wr_en & in_wr_sel,   in_wr_en & ~in_wr_sel};
  assign pop   = {out_rd_en & out_rd_sel, out_rd_en & ~out_rd_sel, IN2_adv, IN1_adv};
  assign wdata = {OUT, OUT, in_wr_data, in_wr_data};

  for (genvar q = 0; q < 4; q++) begin : g_q
    hovalaag_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[q]),
      .pop   (pop[q]),
      .wdata (wdata[q]),
      .rdata (head[q]),
      .count (cnt[q]),
      .full  (full[q])
    );
  end

  // Events use pre-edge occupancy; output-queue empty reads raise no flag.
  assign ovf_ev = push & full;
  assign unf_ev = {IN2_adv && (cnt[1] == '0), IN1_adv && (cnt[0] == '0)};

  // A new event in the same cycle as err_clr survives the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underflow <= '0;
      overflow  <= '0;
    end else begin
      underflow <= (err_clr ? 2'b00 : underflow) | unf_ev;
      overflow  <= (err_clr ? 4'b0000 : overflow) | ovf_ev;
    end
  end

  assign IN1        = head[0];
  assign IN2        = head[1];
  assign out1_data  = head[2];
  assign out2_data  = head[3];
  assign in1_count  = cnt[0];
  assign in2_count  = cnt[1];
  assign out1_count = cnt[2];
  assign out2_count = cnt[3];
endmodule

// File: tb/tb_hovalaag_io_bridge.sv
// Directed bench for hovalaag_io_bridge; queued expectations are popped as heads appear.

module tb_hovalaag_io_bridge;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_wr_en, in_wr_sel, IN1_adv, IN2_adv;
  logic [11:0]   in_wr_data, OUT;
  logic          OUT_valid, OUT_select, out_rd_en, out_rd_sel, err_clr;
  logic [CW-1:0] in1_count, in2_count, out1_count, out2_count;
  logic [11:0]   IN1, IN2, out1_data, out2_data;
  logic [1:0]    underflow;
  logic [3:0]    overflow;

  int errors = 0;
  int checks = 0;
  logic [11:0] sb [$];

  always #5 clk = ~clk;

  hovalaag_io_bridge #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_wr_en(in_wr_en), .in_wr_sel(in_wr_sel), .in_wr_data(in_wr_data),
    .in1_count(in1_count), .in2_count(in2_count), .IN1(IN1), .IN2(IN2),
    .IN1_adv(IN1_adv), .IN2_adv(IN2_adv),
    .OUT(OUT), .OUT_valid(OUT_valid), .OUT_select(OUT_select),
    .out_rd_en(out_rd_en), .out_rd_sel(out_rd_sel),
    .out1_data(out1_data), .out2_data(out2_data),
    .out1_count(out1_count), .out2_count(out2_count),
    .underflow(underflow), .overflow(overflow), .err_clr(err_clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [11:0] e;
    rst_n = 1'b0; in_wr_en = 0; in_wr_sel = 0; in_wr_data = '0; IN1_adv = 0; IN2_adv = 0;
    OUT = '0; OUT_valid = 0; OUT_select = 0; out_rd_en = 0; out_rd_sel = 0; err_clr = 0;
    #12;
    chk("rst_in1_count", 32'(in1_count), 0);
    chk("rst_out2_count", 32'(out2_count), 0);
    chk("rst_IN1", 32'(IN1), 0);
    chk("rst_out1_data", 32'(out1_data), 0);
    chk("rst_flags", {26'd0, underflow, overflow}, 0);
    rst_n = 1'b1;
    tick();

    // write then consume
    in_wr_en = 1; in_wr_sel = 0; in_wr_data = 12'h005; tick();
    in_wr_data = 12'hFFF; tick();
    in_wr_en = 0;
    chk("wc_count", 32'(in1_count), 2);
    chk("wc_head0", 32'(IN1), 32'h005);
    IN1_adv = 1; tick(); IN1_adv = 0;
    chk("wc_head1", 32'(IN1), 32'hFFF);
    IN1_adv = 1; tick(); IN1_adv = 0;
    chk("wc_head_empty", 32'(IN1), 0);
    chk("wc_count_empty", 32'(in1_count), 0);
    chk("wc_underflow", 32'(underflow), 0);

    // fill IN2 past capacity
    in_wr_en = 1; in_wr_sel = 1;
    for (int i = 1; i <= DEPTH + 1; i++) begin
      in_wr_data = 12'(i);
      if (i <= DEPTH) sb.push_back(12'(i));
      tick();
    end
    in_wr_en = 0;
    chk("fill_count", 32'(in2_count), DEPTH);
    chk("fill_overflow", 32'(overflow), 32'b0010);
    for (int i = 0; i < DEPTH; i++) begin
      e = sb.pop_front();
      chk($sformatf("drain_%0d", i), 32'(IN2), 32'(e));
      IN2_adv = 1; tick(); IN2_adv = 0;
    end
    chk("drain_count", 32'(in2_count), 0);
    chk("drain_underflow", 32'(underflow), 0);

    // output capture routing
    OUT_valid = 1; OUT_select = 0; OUT = 12'h123; tick();
    OUT_select = 1; OUT = 12'h456; tick();
    OUT_valid = 0; OUT = 12'h789; tick();
    chk("cap_out1", 32'(out1_data), 32'h123);
    chk("cap_out2", 32'(out2_data), 32'h456);
    chk("cap_out1_count", 32'(out1_count), 1);
    chk("cap_out2_count", 32'(out2_count), 1);
    out_rd_en = 1; out_rd_sel = 1; tick(); out_rd_en = 0;
    chk("cap_out2_drained", 32'(out2_count), 0);
    chk("cap_out2_empty", 32'(out2_data), 0);
    out_rd_en = 1; out_rd_sel = 1; tick(); out_rd_en = 0;
    chk("rd_empty_noflag", {26'd0, underflow, overflow}, 32'b00_0010);

    // simultaneous push/pop, mid-occupancy
    in_wr_en = 1; in_wr_sel = 0;
    for (int i = 1; i <= 3; i++) begin
      in_wr_data = 12'(i * 12'h11); sb.push_back(12'(i * 12'h11)); tick();
    end
    in_wr_data = 12'h044; sb.push_back(12'h044); IN1_adv = 1;
    void'(sb.pop_front());
    tick(); in_wr_en = 0; IN1_adv = 0;
    chk("sim_count", 32'(in1_count), 3);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk("sim_head", 32'(IN1), 32'(e));
      IN1_adv = 1; tick(); IN1_adv = 0;
    end
    chk("sim_drained", 32'(in1_count), 0);

    // simultaneous push/pop on empty
    in_wr_en = 1; in_wr_sel = 0; in_wr_data = 12'h0AA; IN1_adv = 1;
    tick(); in_wr_en = 0; IN1_adv = 0;
    chk("sime_underflow", 32'(underflow), 32'b01);
    chk("sime_count", 32'(in1_count), 1);
    chk("sime_head", 32'(IN1), 32'h0AA);

    // err_clr keeps counts
    err_clr = 1; tick(); err_clr = 0;
    chk("clr_flags", {26'd0, underflow, overflow}, 0);
    chk("clr_in1_count", 32'(in1_count), 1);
    chk("clr_out1_count", 32'(out1_count), 1);

    // OUT2 wrap-around
    for (int i = 0; i < 3 * DEPTH; i++) begin
      OUT_valid = 1; OUT_select = 1; OUT = 12'(i); sb.push_back(12'(i));
      tick(); OUT_valid = 0;
      e = sb.pop_front();
      chk($sformatf("wrap_%0d", i), 32'(out2_data), 32'(e));
      out_rd_en = 1; out_rd_sel = 1; tick(); out_rd_en = 0;
    end
    chk("wrap_count", 32'(out2_count), 0);
    chk("wrap_flags", {26'd0, underflow, overflow}, 0);

    // async reset mid-cycle with everything populated
    IN2_adv = 1; tick(); IN2_adv = 0;
    in_wr_en = 1; in_wr_sel = 1; in_wr_data = 12'h3C3;
    OUT_valid = 1; OUT_select = 1; OUT = 12'h5A5;
    tick(); in_wr_en = 0; OUT_valid = 0;
    chk("pre_rst_counts", {in1_count, in2_count, out1_count, out2_count}, {5'd1, 5'd1, 5'd1, 5'd1});
    chk("pre_rst_underflow", 32'(underflow), 32'b10);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_counts", {in1_count, in2_count, out1_count, out2_count}, 0);
    chk("arst_data", {IN1, IN2, out1_data}, 0);
    chk("arst_out2", 32'(out2_data), 0);
    chk("arst_flags", {26'd0, underflow, overflow}, 0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
